usr_param: RTL and testbench
============================

Name: usr_param

Overview:
- Parametrised universal shift register, successor to the fixed 4-bit USR.
- Adds configurable width, a clock enable, rotate and arithmetic-shift modes, and a multi-cycle burst shift with a busy/done handshake.
- Used as a datapath building block for serialisers, deserialisers and shift-and-add arithmetic.

Parameters:
- WIDTH, 8, register width in bits (legal range 2 or more).
- AMT_W, $clog2(WIDTH)+1, width of the burst amount field. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  clock enable; when low, all state holds.
- modesel  input  3  operation select (see Behaviour).
- Pin  input  WIDTH  parallel load data.
- RSin  input  1  serial input entering the MSB on right shifts.
- LSin  input  1  serial input entering the LSB on left shifts.
- dir  input  1  burst direction: 0 = right, 1 = left.
- amt  input  AMT_W  burst shift count.
- Pout  output  WIDTH  register contents.
- SRout  output  1  equals Pout[0] (combinational).
- SLout  output  1  equals Pout[WIDTH-1] (combinational).
- busy  output  1  burst in progress.
- done  output  1  one-cycle burst-complete pulse.

Behaviour:
- Reset (reset = 0, asynchronous, takes effect immediately):
  - Pout = 0, busy = 0, done = 0, burst counter = 0, FSM = IDLE.
  - Reset has priority over everything, including mid-burst.
- All updates occur on the rising edge of clk when en = 1. With en = 0, all registers hold (burst counter frozen) and done is cleared.
- Modes in IDLE, each a single-cycle operation with the result on Pout after one edge:
  - 000 hold.
  - 001 shift right: {RSin, Pout[W-1:1]}.
  - 010 shift left: {Pout[W-2:0], LSin}.
  - 011 parallel load: Pin.
  - 100 rotate right: {Pout[0], Pout[W-1:1]}.
  - 101 rotate left: {Pout[W-2:0], Pout[W-1]}.
  - 110 arithmetic shift right: {Pout[W-1], Pout[W-1:1]}.
  - 111 burst shift (below).
- Burst shift, accepted only in IDLE:
  - Let N = min(amt, WIDTH).
  - N = 0: no shift; done = 1 for the cycle after the acceptance edge; busy stays 0.
  - N ≥ 1: the acceptance edge performs shift 1 in direction dir, using RSin (right) or LSin (left) sampled at that edge.
    - N = 1: done pulses next cycle; busy never asserts.
    - N > 1: FSM → BUSY, counter = N-1, busy = 1.
  - In BUSY, each enabled edge performs one shift (serial input sampled each edge) and decrements the counter.
  - The edge performing shift N returns the FSM to IDLE, deasserts busy and asserts done for exactly one cycle.
  - Total: exactly N shift edges. busy is high for N-1 enabled cycles.
  - dir, amt, modesel and Pin are ignored while busy. dir is latched at acceptance.
  - A new command is accepted on the edge where done is high (back-to-back bursts allowed).
- done is otherwise 0. It is never asserted outside a burst.
- FSM has 2 states: IDLE and BUSY. There is no illegal-state recovery beyond reset.

Test Plan (WIDTH = 8):
1. Reset and load: assert reset low mid-cycle → Pout = 00, busy = 0, done = 0 immediately. Release, modesel = 011, Pin = B5 → Pout = B5 after 1 edge.
2. Basic shifts: from B5, modesel = 001, RSin = 1 → DA. Then modesel = 010, LSin = 0 → B4. With en = 0 and modesel = 001 → Pout holds B4.
3. Rotate and ASR: load 81, modesel = 100 → C0. Load 81, modesel = 101 → 03. Load 90, modesel = 110 → C8. Check SRout and SLout track Pout[0] and Pout[7].
4. Burst right: load B5, modesel = 111, dir = 0, amt = 3, RSin = 0 → Pout = 16 after 3 edges. busy high for 2 cycles, then done high for exactly 1 cycle. modesel = 011 with Pin = FF applied during busy is ignored.
5. Burst edge cases:
   - Load 00, dir = 1, amt = 12, LSin = 1 → clamped to 8 shifts, Pout = FF, done on the cycle after the 8th shift.
   - amt = 0 → Pout unchanged, busy = 0, done pulses once.
   - Issue a second burst on the done cycle → accepted.
6. Disruptions: during amt = 5 burst, drop en for 3 cycles → Pout and counter freeze, burst completes with 5 total shifts. Assert reset during a burst → Pout = 00, busy = 0, done = 0 asynchronously; the next command starts from IDLE.

Source files
------------

// File: rtl/usr_param.sv
// Parametrised universal shift register with rotate, arithmetic shift
// and a multi-cycle burst shift reporting busy/done.
module usr_param #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       modesel,
  input  logic [WIDTH-1:0] Pin,
  input  logic             RSin,
  input  logic             LSin,
  input  logic             dir,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] Pout,
  output logic             SRout,
  output logic             SLout,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [AMT_W-1:0] WMAX = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] ONE  = AMT_W'(1);

  state_t           state_q;
  logic [AMT_W-1:0] cnt_q;
  logic             dir_q;
  logic [WIDTH-1:0] pout_q;
  logic             done_q;

  logic             bdir;
  logic [WIDTH-1:0] shr;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] burst_p;
  logic [AMT_W-1:0] n;

  // Burst direction comes live from dir on acceptance, latched afterwards.
  always_comb begin
    bdir    = (state_q == BUSY) ? dir_q : dir;
    shr     = {RSin, pout_q[WIDTH-1:1]};
    shl     = {pout_q[WIDTH-2:0], LSin};
    burst_p = bdir ? shl : shr;
    n       = (amt > WMAX) ? WMAX : amt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      pout_q  <= '0;
      done_q  <= 1'b0;
    end else if (!en) begin
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          unique case (modesel)
            3'b000: ;
            3'b001: pout_q <= shr;
            3'b010: pout_q <= shl;
            3'b011: pout_q <= Pin;
            3'b100: pout_q <= {pout_q[0], pout_q[WIDTH-1:1]};
            3'b101: pout_q <= {pout_q[WIDTH-2:0], pout_q[WIDTH-1]};
            3'b110: pout_q <= {pout_q[WIDTH-1], pout_q[WIDTH-1:1]};
            3'b111: begin
              if (n == '0) begin
                done_q <= 1'b1;
              end else begin
                pout_q <= burst_p;
                dir_q  <= dir;
                if (n == ONE) begin
                  done_q <= 1'b1;
                end else begin
                  state_q <= BUSY;
                  cnt_q   <= n - ONE;
                end
              end
            end
          endcase
        end
        BUSY: begin
          pout_q <= burst_p;
          cnt_q  <= cnt_q - ONE;
          if (cnt_q == ONE) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign Pout  = pout_q;
  assign SRout = pout_q[0];
  assign SLout = pout_q[WIDTH-1];
  assign busy  = (state_q == BUSY);
  assign done  = done_q;

endmodule

// File: tb/tb_usr_param.sv
// Bench for usr_param: directed plan plus random stimulus
// against a behavioural model.
module tb_usr_param;
  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    modesel = '0;
  logic [W-1:0]  Pin = '0;
  logic          RSin = 1'b0;
  logic          LSin = 1'b0;
  logic          dir = 1'b0;
  logic [AW-1:0] amt = '0;
  logic [W-1:0]  Pout;
  logic          SRout, SLout, busy, done;

  int cmps = 0;
  int errs = 0;

  usr_param #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .modesel(modesel),
    .Pin(Pin), .RSin(RSin), .LSin(LSin), .dir(dir), .amt(amt),
    .Pout(Pout), .SRout(SRout), .SLout(SLout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // rem = shifts still owed by a running burst
  typedef struct packed {
    logic [7:0] p;
    logic [4:0] rem;
    logic       d;
    logic       done;
  } mdl_t;

  mdl_t m = '0;

  function automatic logic [7:0] sh(input logic [7:0] p,
                                    input logic left, input logic s);
    logic [7:0] r;
    if (left) r = {p[6:0], s};
    else      r = {s, p[7:1]};
    return r;
  endfunction

  function automatic mdl_t nxt(input mdl_t c);
    mdl_t r;
    int   n;
    r      = c;
    r.done = 1'b0;
    if (!en) return r;
    if (c.rem != 0) begin
      r.p    = sh(c.p, c.d, c.d ? LSin : RSin);
      r.rem  = c.rem - 5'd1;
      r.done = (r.rem == 0);
    end else begin
      case (modesel)
        3'd1: r.p = c.p / 2 + (RSin ? 8'd128 : 8'd0);
        3'd2: r.p = c.p * 2 + {7'd0, LSin};
        3'd3: r.p = Pin;
        3'd4: r.p = sh(c.p, 1'b0, c.p[0]);
        3'd5: r.p = sh(c.p, 1'b1, c.p[7]);
        3'd6: r.p = $signed(c.p) >>> 1;
        3'd7: begin
          n = (int'(amt) > W) ? W : int'(amt);
          if (n == 0) begin
            r.done = 1'b1;
          end else begin
            r.p    = sh(c.p, dir, dir ? LSin : RSin);
            r.rem  = 5'(n - 1);
            r.d    = dir;
            r.done = (n == 1);
          end
        end
        default: ;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset)
    if (!reset) m <= '0;
    else        m <= nxt(m);

  task automatic cmp8(input string nm, input logic [7:0] got,
                      input logic [7:0] exp);
    cmps++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp1(input string nm, input logic got, input logic exp);
    cmps++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp8("Pout", Pout, m.p);
    cmp1("busy", busy, m.rem != 0);
    cmp1("done", done, m.done);
    cmp1("SRout", SRout, m.p[0]);
    cmp1("SLout", SLout, m.p[7]);
  end

  task automatic drive(input logic [2:0] ms, input logic [7:0] pi,
                       input logic rs, input logic ls, input logic dr,
                       input logic [3:0] am, input logic e);
    modesel = ms; Pin = pi; RSin = rs; LSin = ls;
    dir = dr; amt = am; en = e;
    @(negedge clk);
  endtask

  task automatic chk3(input string nm, input logic [7:0] p,
                      input logic b, input logic d);
    cmp8({nm, ".Pout"}, Pout, p);
    cmp1({nm, ".busy"}, busy, b);
    cmp1({nm, ".done"}, done, d);
  endtask

  initial begin
    drive(3'd3, 8'hAA, 0, 0, 0, 0, 1);
    chk3("reset", 8'h00, 0, 0);
    reset = 1'b1;
    drive(3'd3, 8'hB5, 0, 0, 0, 0, 1);
    chk3("load", 8'hB5, 0, 0);
    drive(3'd1, 8'h00, 1, 0, 0, 0, 1);
    chk3("shr", 8'hDA, 0, 0);
    drive(3'd2, 8'h00, 0, 0, 0, 0, 1);
    chk3("shl", 8'hB4, 0, 0);
    drive(3'd1, 8'h00, 1, 0, 0, 0, 0);
    chk3("en_hold", 8'hB4, 0, 0);

    drive(3'd3, 8'h81, 0, 0, 0, 0, 1);
    drive(3'd4, 8'h00, 0, 0, 0, 0, 1);
    chk3("ror", 8'hC0, 0, 0);
    drive(3'd3, 8'h81, 0, 0, 0, 0, 1);
    drive(3'd5, 8'h00, 0, 0, 0, 0, 1);
    chk3("rol", 8'h03, 0, 0);
    drive(3'd3, 8'h90, 0, 0, 0, 0, 1);
    drive(3'd6, 8'h00, 0, 0, 0, 0, 1);
    chk3("asr", 8'hC8, 0, 0);
    cmp1("asr.SRout", SRout, 1'b0);
    cmp1("asr.SLout", SLout, 1'b1);

    drive(3'd3, 8'hB5, 0, 0, 0, 0, 1);
    drive(3'd7, 8'h00, 0, 0, 0, 3, 1);
    chk3("br3.e1", 8'h5A, 1, 0);
    drive(3'd3, 8'hFF, 0, 0, 0, 0, 1);
    chk3("br3.e2", 8'h2D, 1, 0);
    drive(3'd3, 8'hFF, 0, 0, 0, 0, 1);
    chk3("br3.e3", 8'h16, 0, 1);
    drive(3'd0, 8'h00, 0, 0, 0, 0, 1);
    chk3("br3.after", 8'h16, 0, 0);

    drive(3'd3, 8'h00, 0, 0, 0, 0, 1);
    drive(3'd7, 8'h00, 0, 1, 1, 12, 1);
    repeat (6) drive(3'd0, 8'h00, 0, 1, 0, 0, 1);
    chk3("clamp.e7", 8'h7F, 1, 0);
    drive(3'd0, 8'h00, 0, 1, 0, 0, 1);
    chk3("clamp.e8", 8'hFF, 0, 1);
    drive(3'd7, 8'h00, 0, 0, 0, 0, 1);
    chk3("amt0", 8'hFF, 0, 1);
    drive(3'd7, 8'h00, 0, 0, 0, 2, 1);
    chk3("b2b.e1", 8'h7F, 1, 0);
    drive(3'd0, 8'h00, 0, 0, 0, 0, 1);
    chk3("b2b.e2", 8'h3F, 0, 1);

    drive(3'd3, 8'h00, 0, 0, 0, 0, 1);
    drive(3'd7, 8'h00, 1, 0, 0, 5, 1);
    drive(3'd0, 8'h00, 1, 0, 0, 0, 1);
    repeat (3) drive(3'd0, 8'h00, 1, 0, 0, 0, 0);
    chk3("enfrz", 8'hC0, 1, 0);
    drive(3'd0, 8'h00, 1, 0, 0, 0, 1);
    drive(3'd0, 8'h00, 1, 0, 0, 0, 1);
    chk3("enfrz.e4", 8'hF0, 1, 0);
    drive(3'd0, 8'h00, 1, 0, 0, 0, 1);
    chk3("enfrz.e5", 8'hF8, 0, 1);

    drive(3'd7, 8'h00, 0, 0, 0, 5, 1);
    drive(3'd0, 8'h00, 0, 0, 0, 0, 1);
    chk3("rstb.e2", 8'h3E, 1, 0);
    #2 reset = 1'b0;
    #1 chk3("rstb.async", 8'h00, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(3'd3, 8'hA5, 0, 0, 0, 0, 1);
    chk3("rstb.load", 8'hA5, 0, 0);

    repeat (4000) begin
      if ($urandom_range(0, 249) == 0) begin
        #2 reset = 1'b0;
        #1 reset = 1'b1;
      end
      drive(3'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom),
            4'($urandom_range(0, 15)), $urandom_range(0, 9) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
